// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU-side SRAM-like bus blocks.
//   arb_state_e : arbiter transaction state
//   owner_e     : which cache port owns the master port
//   SZ_*        : access size codes carried on the *_size buses
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between the i-cache and d-cache requests.
// Purely combinational; the rr_last history register lives in the parent.
//   req_i   : i-side request
//   req_d   : d-side request
//   rr_last : owner granted most recently
//   winner  : selected owner (meaningful only when a request is present)
module rr_arb2
  import cpu_bus_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_e rr_last,
  output owner_e winner
);

  always_comb begin
    winner = OWN_INST;
    if (req_i && req_d) begin
      winner = (rr_last == OWN_INST) ? OWN_DATA : OWN_INST;
    end else if (req_d) begin
      winner = OWN_DATA;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like master port between the i-cache and d-cache ports.
// One transaction outstanding at a time; handshakes return to the owner only.
//   clk, rst            : clock, synchronous active-high reset
//   inst_* / data_*     : requester ports (req, wr, size, addr, wdata in;
//                         rdata, addr_ok, data_ok out)
//   m_*                 : master port toward the AXI bridge
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | no transaction; winner passed through at once
//   ST_ADDR | grant locked to owner, waiting for m_addr_ok
//   ST_DATA | address accepted, waiting for m_data_ok
module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,

  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     rr_last_q, rr_last_d;
  owner_e     winner;
  owner_e     sel;
  logic       owner_req;
  logic       addr_ok;
  logic       data_ok;

  rr_arb2 u_rr_arb2 (
    .req_i   (inst_req),
    .req_d   (data_req),
    .rr_last (rr_last_q),
    .winner  (winner)
  );

  assign owner_req = (owner_q == OWN_DATA) ? data_req : inst_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_DATA;
      rr_last_q <= OWN_INST;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    sel       = owner_q;
    m_req     = 1'b0;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sel   = winner;
        m_req = inst_req | data_req;
        if (m_req) begin
          owner_d = winner;
          if (m_addr_ok) begin
            addr_ok   = 1'b1;
            rr_last_d = winner;
            state_d   = ST_DATA;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        m_req = owner_req;
        // A withdrawn request abandons the grant without touching rr_last,
        // so the withdrawing side keeps its round-robin priority.
        if (!owner_req) begin
          state_d = ST_IDLE;
        end else if (m_addr_ok) begin
          addr_ok   = 1'b1;
          rr_last_d = owner_q;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (m_data_ok) begin
          data_ok = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign m_wr    = (sel == OWN_DATA) ? data_wr    : inst_wr;
  assign m_size  = (sel == OWN_DATA) ? data_size  : inst_size;
  assign m_addr  = (sel == OWN_DATA) ? data_addr  : inst_addr;
  assign m_wdata = (sel == OWN_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = addr_ok & (sel == OWN_INST);
  assign data_addr_ok = addr_ok & (sel == OWN_DATA);
  assign inst_data_ok = data_ok & (sel == OWN_INST);
  assign data_data_ok = data_ok & (sel == OWN_DATA);

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

endmodule
